instr_bus_server: RTL and testbench
===================================

INSTR_BUS_SERVER -- requirements
Module: instr_bus_server

Interface
REQ-001 Parameter NUM_CORES, default 4, number of attached cores (2..16).
REQ-002 Parameter INSTR_WIDTH, default 2, instruction width; matches bus_instruction_t encoding.
REQ-003 Localparam CORE_ID_WIDTH = $clog2(NUM_CORES), core index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 bus  bus_if.server modport  --  inputs send_req[NUM_CORES], broadcast_mode[NUM_CORES], dst_ids[NUM_CORES*CORE_ID_WIDTH], instructions[NUM_CORES*INSTR_WIDTH]; outputs send_grant[NUM_CORES], recv_valid[NUM_CORES], src_id[CORE_ID_WIDTH], instruction[INSTR_WIDTH].
REQ-007 busy  output  1  high while FSM is in DELIVER.

Function
REQ-008 FSM states SHALL be IDLE and DELIVER; all bus outputs SHALL be registered.
REQ-009 IDLE, no send_req bit set: SHALL remain IDLE, all outputs zero except held src_id/instruction.
REQ-010 IDLE, any send_req bit set: SHALL select winner w by round-robin, latch w's payload, go to DELIVER at next edge.
REQ-011 Round-robin: search starts at rr_ptr, ascending, wrapping NUM_CORES-1 -> 0; first set bit wins.
REQ-012 rr_ptr SHALL update to (w+1) mod NUM_CORES on each IDLE->DELIVER transition; unchanged otherwise.
REQ-013 DELIVER SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-014 In DELIVER: send_grant = one-hot bit w; src_id = w; instruction = instructions slice w; busy = 1.
REQ-015 In DELIVER, broadcast_mode[w]=1: recv_valid SHALL have every bit set except bit w; dst_ids[w] ignored.
REQ-016 In DELIVER, broadcast_mode[w]=0: recv_valid SHALL be one-hot at dst_ids slice w.
REQ-017 Unicast with dst == w (self-addressed) or dst >= NUM_CORES: recv_valid SHALL be all-zero; grant still issued.
REQ-018 Latency: request sampled in IDLE at edge N -> grant and delivery visible in cycle N+1 (one cycle).
REQ-019 Handshake: core holds send_req and payload until it observes its send_grant; core drops send_req at the following edge; throughput one message per two cycles.
REQ-020 Payload changes on non-winning cores during DELIVER SHALL NOT affect the latched delivery.
REQ-021 send_req of a non-winner SHALL remain pending and be served later; any requester served within NUM_CORES grants.
REQ-022 send_grant and recv_valid SHALL be zero outside DELIVER; src_id and instruction SHALL hold last delivered value.
REQ-023 Instruction SHALL pass unmodified; server does not interpret HALT_PAUSE/STOP/CONTINUE/DONE.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, rr_ptr 0, send_grant 0, recv_valid 0, src_id 0, instruction 0, busy 0.
REQ-025 Reset asserted during DELIVER SHALL abort delivery immediately; no grant or recv_valid after release until a new request is sampled.
REQ-026 First IDLE cycle after reset release SHALL arbitrate normally starting at core 0.

Verification
REQ-027 Reset, then core 2 unicast to core 0 with instruction 2'b01 -> one cycle later send_grant=4'b0100, recv_valid=4'b0001, src_id=2, instruction=2'b01, busy=1 for one cycle.
REQ-028 Core 1 broadcast 2'b10 (NUM_CORES=4) -> recv_valid=4'b1101, src_id=1, send_grant=4'b0010.
REQ-029 Cores 0,1,3 request simultaneously, held until granted -> grants in order 0,1,3, each one cycle with one IDLE cycle between; rr_ptr ends at 0 (wrap).
REQ-030 Core 3 unicast to itself -> send_grant=4'b1000, recv_valid=4'b0000; NUM_CORES=3 build with dst=3 -> recv_valid=3'b000.
REQ-031 rst_n pulsed low during DELIVER -> send_grant, recv_valid, busy zero asynchronously; after release with requests idle, outputs stay zero.
REQ-032 All cores request continuously for 40 cycles -> each core granted exactly 5 times, no two grants in consecutive cycles, grant count difference between cores never exceeds 1.

Source files
------------

// File: rtl/instr_bus_server.sv
// Round-robin message server: picks one requesting core and delivers its instruction
// to one core, or to every other core, for a single registered cycle.
module instr_bus_server #(
  parameter  int NUM_CORES     = 4,
  parameter  int INSTR_WIDTH   = 2,
  localparam int CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CORES-1:0]               send_req,
  input  logic [NUM_CORES-1:0]               broadcast_mode,
  input  logic [NUM_CORES*CORE_ID_WIDTH-1:0] dst_ids,
  input  logic [NUM_CORES*INSTR_WIDTH-1:0]   instructions,
  output logic [NUM_CORES-1:0]               send_grant,
  output logic [NUM_CORES-1:0]               recv_valid,
  output logic [CORE_ID_WIDTH-1:0]           src_id,
  output logic [INSTR_WIDTH-1:0]             instruction,
  output logic                               busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    DELIVER = 1'b1
  } state_t;

  state_t                   state, state_next;
  logic [CORE_ID_WIDTH-1:0] rr_ptr, rr_next;
  logic [CORE_ID_WIDTH-1:0] winner;
  logic                     found;
  logic [CORE_ID_WIDTH-1:0] dst_sel;
  logic [INSTR_WIDTH-1:0]   instr_sel;
  logic [NUM_CORES-1:0]     recv_calc;
  logic [NUM_CORES-1:0]     grant_next, recv_next;
  logic [CORE_ID_WIDTH-1:0] src_next;
  logic [INSTR_WIDTH-1:0]   instr_next;

  // Round-robin search: first requester at or after rr_ptr, wrapping past the top core.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found && send_req[(int'(rr_ptr) + i) % NUM_CORES]) begin
        found  = 1'b1;
        winner = CORE_ID_WIDTH'((int'(rr_ptr) + i) % NUM_CORES);
      end
    end
  end

  assign dst_sel   = dst_ids[int'(winner)*CORE_ID_WIDTH +: CORE_ID_WIDTH];
  assign instr_sel = instructions[int'(winner)*INSTR_WIDTH +: INSTR_WIDTH];

  // Broadcast reaches every core but the sender; a self-addressed or out-of-range
  // unicast reaches nobody, though the sender is still granted.
  always_comb begin
    recv_calc = '0;
    if (broadcast_mode[winner]) begin
      recv_calc = ~(NUM_CORES'(1) << winner);
    end else if (int'(dst_sel) < NUM_CORES && dst_sel != winner) begin
      recv_calc = NUM_CORES'(1) << dst_sel;
    end
  end

  always_comb begin
    state_next = IDLE;
    rr_next    = rr_ptr;
    grant_next = '0;
    recv_next  = '0;
    src_next   = src_id;
    instr_next = instruction;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = DELIVER;
          rr_next    = CORE_ID_WIDTH'((int'(winner) + 1) % NUM_CORES);
          grant_next = NUM_CORES'(1) << winner;
          recv_next  = recv_calc;
          src_next   = winner;
          instr_next = instr_sel;
        end
      end
      DELIVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_next;
      rr_ptr <= rr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_grant  <= '0;
      recv_valid  <= '0;
      src_id      <= '0;
      instruction <= '0;
    end else begin
      send_grant  <= grant_next;
      recv_valid  <= recv_next;
      src_id      <= src_next;
      instruction <= instr_next;
    end
  end

  assign busy = (state == DELIVER);

endmodule

// File: tb/tb_instr_bus_server.sv
// Bench for instr_bus_server: directed scenarios plus randomized handshaking cores,
// all checked against a transaction-level reference model.
module tb_instr_bus_server;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    send_req, broadcast_mode, send_grant, recv_valid;
  logic [N*CW-1:0] dst_ids;
  logic [N*IW-1:0] instructions;
  logic [CW-1:0]   src_id;
  logic [IW-1:0]   instruction;
  logic            busy;

  logic [2:0] req3, bc3, grant3, recv3;
  logic [5:0] dst3, ins3;
  logic [1:0] src3, instr3;
  logic       busy3;

  instr_bus_server #(.NUM_CORES(N), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .send_req(send_req), .broadcast_mode(broadcast_mode),
    .dst_ids(dst_ids), .instructions(instructions),
    .send_grant(send_grant), .recv_valid(recv_valid),
    .src_id(src_id), .instruction(instruction), .busy(busy)
  );

  instr_bus_server #(.NUM_CORES(3), .INSTR_WIDTH(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .send_req(req3), .broadcast_mode(bc3),
    .dst_ids(dst3), .instructions(ins3),
    .send_grant(grant3), .recv_valid(recv3),
    .src_id(src3), .instruction(instr3), .busy(busy3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: rotating priority pointer, "last cycle delivered" flag, held payload.
  int         m_rr, m_src, m_instr;
  bit         m_busy;
  logic [N-1:0] e_grant, e_recv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int c, input bit req, input bit bc, input int dst, input int ins);
    send_req[c]            = req;
    broadcast_mode[c]      = bc;
    dst_ids[c*CW +: CW]    = CW'(dst);
    instructions[c*IW +: IW] = IW'(ins);
  endtask

  task automatic clear_inputs();
    send_req = '0; broadcast_mode = '0; dst_ids = '0; instructions = '0;
    req3 = '0; bc3 = '0; dst3 = '0; ins3 = '0;
  endtask

  task automatic predict();
    int w;
    int d;
    e_grant = '0;
    e_recv  = '0;
    if (!m_busy && send_req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && send_req[(m_rr + k) % N]) w = (m_rr + k) % N;
      e_grant[w] = 1'b1;
      if (broadcast_mode[w]) begin
        for (int j = 0; j < N; j++) e_recv[j] = (j != w);
      end else begin
        d = int'(dst_ids[w*CW +: CW]);
        if (d < N && d != w) e_recv[d] = 1'b1;
      end
      m_src   = w;
      m_instr = int'(instructions[w*IW +: IW]);
      m_rr    = (w + 1) % N;
      m_busy  = 1'b1;
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic tick(input string tag);
    predict();
    @(posedge clk);
    #1;
    check({tag, "_grant"}, send_grant, e_grant);
    check({tag, "_recv"},  recv_valid, e_recv);
    check({tag, "_src"},   src_id, m_src);
    check({tag, "_instr"}, instruction, m_instr);
    check({tag, "_busy"},  busy, m_busy);
  endtask

  task automatic model_reset();
    m_rr = 0; m_src = 0; m_instr = 0; m_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    check("rst_grant", send_grant, 0);
    check("rst_recv", recv_valid, 0);
    check("rst_src", src_id, 0);
    check("rst_instr", instruction, 0);
    check("rst_busy", busy, 0);
    check("rst_grant3", grant3, 0);
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt[N];
    int order[3];
    logic [N-1:0] prev;
    int mx, mn;
    bit pend[N];
    bit drop_next[N];

    rst_n = 1'b1;
    clear_inputs();
    model_reset();
    do_reset();

    // Core 2 unicast to core 0, instruction 2'b01.
    set_core(2, 1, 0, 0, 1);
    tick("u27");
    check("u27c_grant", send_grant, 4'b0100);
    check("u27c_recv", recv_valid, 4'b0001);
    check("u27c_src", src_id, 2);
    check("u27c_instr", instruction, 2'b01);
    check("u27c_busy", busy, 1);
    tick("u27_after");
    set_core(2, 0, 0, 0, 1);
    tick("u27_idle");

    // Core 1 broadcast 2'b10, dst field ignored.
    set_core(1, 1, 1, 1, 2);
    tick("b28");
    check("b28c_grant", send_grant, 4'b0010);
    check("b28c_recv", recv_valid, 4'b1101);
    check("b28c_src", src_id, 1);
    tick("b28_after");
    set_core(1, 0, 0, 0, 0);
    tick("b28_idle");

    // Cores 0,1,3 together from a fresh pointer: served 0,1,3 then pointer wraps to 0.
    do_reset();
    order = '{0, 1, 3};
    set_core(0, 1, 0, 2, 3);
    set_core(1, 1, 0, 3, 2);
    set_core(3, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick("rr29");
      check("rr29c_grant", send_grant, 32'(1) << order[i]);
      tick("rr29_gap");
      check("rr29c_gap", send_grant, 0);
      send_req[order[i]] = 1'b0;
    end
    set_core(0, 1, 0, 1, 2);
    set_core(3, 1, 0, 1, 2);
    tick("rr29_wrap");
    check("rr29c_wrap", send_grant, 4'b0001);
    tick("rr29_wrap_after");
    clear_inputs();
    tick("rr29_idle");

    // Self-addressed unicast, plus out-of-range destination on a 3-core build.
    set_core(3, 1, 0, 3, 2);
    req3 = 3'b010; dst3[3:2] = 2'd3; ins3[3:2] = 2'b11;
    tick("s30");
    check("s30c_grant", send_grant, 4'b1000);
    check("s30c_recv", recv_valid, 4'b0000);
    check("s30c_grant3", grant3, 3'b010);
    check("s30c_recv3", recv3, 3'b000);
    check("s30c_instr3", instr3, 2'b11);
    tick("s30_after");
    clear_inputs();
    req3 = 3'b001; bc3 = 3'b001;
    tick("s30_bc3");
    check("s30c_bc3_recv", recv3, 3'b110);
    check("s30c_bc3_src", src3, 0);
    tick("s30_bc3_after");
    clear_inputs();
    tick("s30_idle");

    // Reset pulse in the middle of a delivery aborts it immediately.
    set_core(1, 1, 0, 2, 3);
    tick("r31_deliver");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("r31_grant", send_grant, 0);
    check("r31_recv", recv_valid, 0);
    check("r31_busy", busy, 0);
    check("r31_src", src_id, 0);
    clear_inputs();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("r31_quiet");

    // All cores request continuously for 40 cycles.
    do_reset();
    for (int c = 0; c < N; c++) begin
      set_core(c, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      cnt[c] = 0;
    end
    prev = '0;
    for (int t = 0; t < 40; t++) begin
      tick("f32");
      for (int c = 0; c < N; c++) if (send_grant[c]) cnt[c]++;
      check("f32_consec", (|send_grant) & (|prev), 0);
      prev = send_grant;
      mx = cnt[0]; mn = cnt[0];
      for (int c = 1; c < N; c++) begin
        if (cnt[c] > mx) mx = cnt[c];
        if (cnt[c] < mn) mn = cnt[c];
      end
      check("f32_balance", 32'(mx - mn <= 1), 1);
    end
    for (int c = 0; c < N; c++) check($sformatf("f32_count%0d", c), cnt[c], 5);
    clear_inputs();
    tick("f32_drain");
    tick("f32_idle");

    // Random cores following the request/grant handshake; idle cores scramble payloads.
    do_reset();
    for (int c = 0; c < N; c++) begin pend[c] = 1'b0; drop_next[c] = 1'b0; end
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < N; c++) begin
        if (!pend[c]) begin
          set_core(c, 1'b0, 1'($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
          if ($urandom_range(0, 2) == 0) begin
            pend[c] = 1'b1;
            send_req[c] = 1'b1;
          end
        end
      end
      tick("rand");
      for (int c = 0; c < N; c++) begin
        if (drop_next[c]) begin
          drop_next[c] = 1'b0;
          pend[c] = 1'b0;
          send_req[c] = 1'b0;
        end
        if (e_grant[c]) drop_next[c] = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
